// File: rtl/pipelined_skip_addsub_pkg.sv
// Shared defaults and parameter legality check for the pipelined carry-skip
// adder/subtractor. Also intended for reuse by the multiplier partial-product adder.
package pipelined_skip_addsub_pkg;

   localparam int DEF_WIDTH = 128;
   localparam int DEF_K     = 16;
   localparam int DEF_BPS   = 2;

   // True when WIDTH splits into whole K-bit blocks and the block count splits
   // into whole stages of BPS blocks each.
   function automatic bit skip_params_ok(input int width, input int k, input int bps);
      bit ok;
      ok = 1'b1;
      if (k <= 0 || bps <= 0 || width <= 0) begin
         ok = 1'b0;
      end else if ((width % k) != 0) begin
         ok = 1'b0;
      end else if (((width / k) % bps) != 0) begin
         ok = 1'b0;
      end else begin
         ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/pipelined_skip_addsub_skip_block.sv
// K-bit carry-skip block: a ripple chain of full adders whose carry-out is
// bypassed straight from carry-in when every bit position propagates.
module skip_block #(
   parameter int K = 16
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   input  logic         cin,
   output logic [K-1:0] s,
   output logic         cout,
   output logic         p,
   output logic         c_msb
);

   logic [K:0] c_s;

   // Ripple chain: sum bits always come from here, never from the skip path.
   always_comb begin
      c_s    = '0;
      s      = '0;
      c_s[0] = cin;
      for (int i = 0; i < K; i++) begin
         s[i]       = a[i] ^ b[i] ^ c_s[i];
         c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
      end
   end

   // Whole-block propagate selects the skip path for the carry.
   assign p     = &(a ^ b);
   assign cout  = p ? cin : c_s[K];
   assign c_msb = c_s[K-1];

endmodule

// File: rtl/pipelined_skip_addsub.sv
// Pipelined carry-skip adder/subtractor. Each stage resolves BPS skip blocks
// and registers the running carry, partial sum and operands. All stages move
// together on a single global advance, so a stalled output freezes the chain.
module pipelined_skip_addsub
   import pipelined_skip_addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int K     = DEF_K,
   parameter int BPS   = DEF_BPS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NB = WIDTH / K;
   localparam int NS = NB / BPS;
   localparam int SW = BPS * K;

   if (!skip_params_ok(WIDTH, K, BPS)) begin : g_bad_params
      $error("pipelined_skip_addsub: WIDTH must be a multiple of K and WIDTH/K a multiple of BPS");
   end

   // Per-stage inputs: index 0 is the live input beat, index j>0 is the
   // register bank written by stage j-1.
   logic [NS-1:0][WIDTH-1:0] opa_s;
   logic [NS-1:0][WIDTH-1:0] opb_s;
   logic [NS-1:0][WIDTH-1:0] psum_s;
   logic [NS-1:0]            cin_s;
   logic [NS-1:0]            vin_s;
   // Per-stage combinational results.
   logic [NS-1:0][WIDTH-1:0] sum_d_s;
   logic [NS-1:0]            cout_d_s;
   logic                     cmsb_s;

   logic             adv_s;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_sum_q;
   logic             out_cout_q;
   logic             out_ovf_q;

   // One advance for the whole chain; depends only on the output side.
   assign adv_s    = !out_valid_q || out_ready;
   assign in_ready = adv_s;

   // Subtraction is A + ~B + 1: invert B and inject the 1 as carry-in.
   assign opa_s[0]  = in_a;
   assign opb_s[0]  = in_sub ? ~in_b : in_b;
   assign psum_s[0] = '0;
   assign cin_s[0]  = in_sub;
   assign vin_s[0]  = in_valid;

   for (genvar j = 0; j < NS; j++) begin : g_stage
      logic [BPS:0]       bc_s;
      logic [SW-1:0]      ssum_s;
      logic [BPS-1:0]     bp_s;
      logic [BPS-1:0]     bm_s;
      logic [WIDTH-1:0]   sd_s;

      assign bc_s[0] = cin_s[j];

      for (genvar b = 0; b < BPS; b++) begin : g_blk
         skip_block #(.K(K)) u_blk (
            .a     (opa_s[j][(j*BPS + b)*K +: K]),
            .b     (opb_s[j][(j*BPS + b)*K +: K]),
            .cin   (bc_s[b]),
            .s     (ssum_s[b*K +: K]),
            .cout  (bc_s[b + 1]),
            .p     (bp_s[b]),
            .c_msb (bm_s[b])
         );
      end

      // Splice this stage's freshly resolved sum bits into the partial sum.
      always_comb begin
         sd_s               = psum_s[j];
         sd_s[j*SW +: SW]   = ssum_s;
      end

      assign sum_d_s[j]  = sd_s;
      assign cout_d_s[j] = bc_s[BPS];

      if (j == NS - 1) begin : g_last
         assign cmsb_s = bm_s[BPS-1];
      end else begin : g_reg
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] b_q;
         logic [WIDTH-1:0] sum_q;
         logic             c_q;
         logic             v_q;

         // Inter-stage register: captures on advance, holds (bubbles included) otherwise.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q   <= '0;
               b_q   <= '0;
               sum_q <= '0;
               c_q   <= 1'b0;
               v_q   <= 1'b0;
            end else if (adv_s) begin
               a_q   <= opa_s[j];
               b_q   <= opb_s[j];
               sum_q <= sd_s;
               c_q   <= bc_s[BPS];
               v_q   <= vin_s[j];
            end
         end

         assign opa_s[j+1]  = a_q;
         assign opb_s[j+1]  = b_q;
         assign psum_s[j+1] = sum_q;
         assign cin_s[j+1]  = c_q;
         assign vin_s[j+1]  = v_q;
      end
   end

   // Output register: final sum, carry and overflow, frozen while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else if (adv_s) begin
         out_valid_q <= vin_s[NS-1];
         out_sum_q   <= sum_d_s[NS-1];
         out_cout_q  <= cout_d_s[NS-1];
         out_ovf_q   <= cmsb_s ^ cout_d_s[NS-1];
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_pipelined_skip_addsub.sv
// Self-checking bench for pipelined_skip_addsub at default parameters.
// Directed vectors carry hand-computed results; streams use a reference model.
// Every accepted beat pushes its expected result; the output monitor pops it.
module tb_pipelined_skip_addsub;

   localparam int W   = 128;
   localparam int KB  = 16;
   localparam int BPS = 2;
   localparam int NS  = (W / KB) / BPS;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   always #5 clk = ~clk;

   pipelined_skip_addsub #(.WIDTH(W), .K(KB), .BPS(BPS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } exp_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      exp_t         e;
   } vec_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference: {cout,sum} = A + (sub ? ~B : B) + sub; ovf = carry into MSB ^ carry out.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic [W:0]   r;
      logic [W-1:0] bb;
      exp_t         e;
      bb  = sub ? ~b : b;
      r   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
      e.s = r[W-1:0];
      e.c = r[W];
      e.o = (a[W-1] ^ bb[W-1] ^ r[W-1]) ^ r[W];
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0: v = '0;
         1: v = '1;
         2: v = {1'b0, {(W-1){1'b1}}};
         3: v = {1'b1, {(W-1){1'b0}}};
         default: v = {$urandom, $urandom, $urandom, $urandom};
      endcase
      return v;
   endfunction

   task automatic check1(input string name, input logic act, input logic want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0b want %0b at %0t", name, act, want, $time);
      end
   endtask

   // Output monitor: in_ready relation, stall stability, scoreboard compare.
   logic hold_v = 1'b0;
   exp_t held;
   always @(negedge clk) begin
      if (rst_n) begin
         check1("in_ready", in_ready, !out_valid || out_ready);
         if (hold_v) begin
            total++;
            if (!out_valid || {out_sum, out_cout, out_ovf} !== held) begin
               bad++;
               $display("FAIL stall_stable: got v=%0b %h/%0b/%0b want %h/%0b/%0b",
                        out_valid, out_sum, out_cout, out_ovf, held.s, held.c, held.o);
            end
         end
         hold_v = out_valid && !out_ready;
         held   = {out_sum, out_cout, out_ovf};
         if (out_valid && out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_result: got %h/%0b/%0b with empty scoreboard",
                        out_sum, out_cout, out_ovf);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               if ({out_sum, out_cout, out_ovf} !== e) begin
                  bad++;
                  $display("FAIL result: got sum=%h cout=%0b ovf=%0b want sum=%h cout=%0b ovf=%0b",
                           out_sum, out_cout, out_ovf, e.s, e.c, e.o);
               end
            end
         end
      end else begin
         hold_v = 1'b0;
      end
   end

   // Single beat into an empty pipe; checks it emerges exactly NS edges after acceptance.
   task automatic one_beat(input vec_t v);
      int lat;
      bit seen;
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = v.a;
      in_b      = v.b;
      in_sub    = v.sub;
      @(negedge clk);
      check1("accept_ready", in_ready, 1'b1);
      sb_q.push_back(v.e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            lat++;
         end
      end
      total++;
      if (lat != NS) begin
         bad++;
         $display("FAIL latency: got %0d want %0d", lat, NS);
      end
      repeat (2) @(posedge clk);
   endtask

   // Streaming driver. mode 0: 8 back-to-back alternating add/sub beats with
   // out_ready low in cycles 5-7. mode 1: random beats, bubbles and backpressure.
   task automatic stream(input int n, input int mode);
      int           sent = 0;
      int           cyc  = 0;
      logic [W-1:0] a, b;
      logic         s;
      a = pick(); b = pick(); s = 1'b0;
      while ((sent < n || sb_q.size() != 0) && cyc < 20 * n + 100) begin
         @(posedge clk); #1;
         cyc++;
         if (mode == 0) out_ready = !(cyc >= 5 && cyc <= 7);
         else           out_ready = ($urandom_range(0, 3) != 0);
         if (sent < n) begin
            in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
            in_a = a; in_b = b; in_sub = s;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (mode == 0 && cyc == 6) check1("stall_in_ready", in_ready, 1'b0);
         if (in_valid && in_ready) begin
            sb_q.push_back(model(a, b, s));
            sent++;
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? ~a : pick();
            s = (mode == 0) ? sent[0] : 1'($urandom_range(0, 1));
         end
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      total++;
      if (sent != n || sb_q.size() != 0) begin
         bad++;
         $display("FAIL stream_drain: sent=%0d of %0d, pending=%0d", sent, n, sb_q.size());
      end
   endtask

   vec_t tbl[7];

   initial begin
      logic [W-1:0] ones;
      logic [W-1:0] maxpos;
      logic [W-1:0] minneg;
      ones   = '1;
      maxpos = {1'b0, {(W-1){1'b1}}};
      minneg = {1'b1, {(W-1){1'b0}}};
      tbl[0] = '{a: W'(127),  b: W'(45), sub: 1'b0, e: '{s: W'(172),       c: 1'b0, o: 1'b0}};
      tbl[1] = '{a: ones,     b: W'(1),  sub: 1'b0, e: '{s: W'(0),         c: 1'b1, o: 1'b0}};
      tbl[2] = '{a: maxpos,   b: W'(1),  sub: 1'b0, e: '{s: minneg,        c: 1'b0, o: 1'b1}};
      tbl[3] = '{a: W'(27),   b: W'(4),  sub: 1'b1, e: '{s: W'(23),        c: 1'b1, o: 1'b0}};
      tbl[4] = '{a: W'(4),    b: W'(27), sub: 1'b1, e: '{s: ones - W'(22), c: 1'b0, o: 1'b0}};
      tbl[5] = '{a: minneg,   b: W'(1),  sub: 1'b1, e: '{s: maxpos,        c: 1'b1, o: 1'b1}};
      tbl[6] = '{a: W'(0),    b: W'(0),  sub: 1'b1, e: '{s: W'(0),         c: 1'b1, o: 1'b0}};

      // Reset state.
      #12;
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_out_cout", out_cout, 1'b0);
      check1("rst_out_ovf", out_ovf, 1'b0);
      check1("rst_out_sum_zero", (out_sum == '0), 1'b1);
      check1("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors with latency check each.
      for (int i = 0; i < 7; i++) one_beat(tbl[i]);

      // Back-to-back mixed stream with a 3-cycle stall.
      stream(8, 0);

      // Asynchronous reset with the pipeline full and the output stalled.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_a = pick(); in_b = pick(); in_sub = i[0];
         @(negedge clk);
         if (in_valid && in_ready) sb_q.push_back(model(in_a, in_b, in_sub));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check1("pre_rst_out_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check1("async_rst_out_valid", out_valid, 1'b0);
      check1("async_rst_out_sum_zero", (out_sum == '0), 1'b1);
      check1("async_rst_out_cout", out_cout, 1'b0);
      sb_q.delete();
      out_ready = 1'b1;
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check1("no_stale_after_rst", out_valid, 1'b0);
      end
      one_beat(tbl[0]);

      // Long random stream under random backpressure and bubbles.
      stream(2000, 1);

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
